dmem_store_buffer: RTL and testbench

//  Posted-write store buffer between the MEM pipeline stage and the data cache.

---
 rtl/dmem_store_buffer.sv | 149 ++++++++++++++
 tb/tb_dmem_store_buffer.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_store_buffer.sv
// Posted-write store buffer between the MEM stage and the data cache.
// Queues stores in a small FIFO, drains them one at a time, and orders loads behind stores to the same word.
module dmem_store_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_write_data,
    input  logic        cpu_memwrite,
    input  logic        cpu_memread,
    input  logic [3:0]  cpu_sign_mask,
    output logic [31:0] cpu_read_data,
    output logic        cpu_stall,
    output logic [31:0] cache_addr,
    output logic [31:0] cache_write_data,
    output logic        cache_memwrite,
    output logic        cache_memread,
    output logic [3:0]  cache_sign_mask,
    input  logic [31:0] cache_read_data,
    input  logic        cache_stall
);

    typedef enum logic [2:0] {
        IDLE,
        WR_ISSUE,
        WR_WAIT,
        LD_ISSUE,
        LD_WAIT,
        LD_DONE
    } state_t;

    localparam logic [PTR_W:0]   FullCount = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CountOne  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PtrOne    = PTR_W'(1);

    state_t           state_q, state_d;
    logic [31:0]      addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [3:0]       mask_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             full, enq, pop, hit;

    assign full      = (count_q == FullCount);
    assign enq       = cpu_memwrite && !full;
    assign pop       = (state_q == WR_WAIT) && !cache_stall;
    assign cpu_stall = (cpu_memwrite && full) || (cpu_memread && (state_q != LD_DONE));
    assign cpu_read_data = rdata_q;

    // An entry is live when its distance from the head is below the occupancy.
    always_comb begin
        logic [PTR_W-1:0] offset;
        hit    = 1'b0;
        offset = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset = PTR_W'(i) - rd_ptr_q;
            if (({1'b0, offset} < count_q) && (addr_q[i][31:2] == cpu_addr[31:2])) begin
                hit = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        rdata_d  = rdata_q;
        case (state_q)
            IDLE: begin
                if (cpu_memread && !hit) begin
                    state_d = LD_ISSUE;
                end else if (count_q != '0) begin
                    state_d = WR_ISSUE;
                end
            end
            WR_ISSUE: state_d = WR_WAIT;
            WR_WAIT:  if (!cache_stall) state_d = IDLE;
            LD_ISSUE: state_d = LD_WAIT;
            LD_WAIT: begin
                if (!cache_stall) begin
                    state_d = LD_DONE;
                    rdata_d = cache_read_data;
                end
            end
            LD_DONE:  state_d = IDLE;
            default:  state_d = IDLE;
        endcase
        if (enq) wr_ptr_d = wr_ptr_q + PtrOne;
        if (pop) rd_ptr_d = rd_ptr_q + PtrOne;
        if (enq && !pop) begin
            count_d = count_q + CountOne;
        end else if (!enq && pop) begin
            count_d = count_q - CountOne;
        end
    end

    // The cache bus is a pure function of state, so it stays put for the whole issue/wait window.
    always_comb begin
        cache_addr       = '0;
        cache_write_data = '0;
        cache_sign_mask  = '0;
        cache_memwrite   = 1'b0;
        cache_memread    = 1'b0;
        case (state_q)
            WR_ISSUE, WR_WAIT: begin
                cache_addr       = addr_q[rd_ptr_q];
                cache_write_data = data_q[rd_ptr_q];
                cache_sign_mask  = mask_q[rd_ptr_q];
                cache_memwrite   = (state_q == WR_ISSUE);
            end
            LD_ISSUE, LD_WAIT: begin
                cache_addr      = cpu_addr;
                cache_sign_mask = cpu_sign_mask;
                cache_memread   = (state_q == LD_ISSUE);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            rdata_q  <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && enq) begin
            addr_q[wr_ptr_q] <= cpu_addr;
            data_q[wr_ptr_q] <= cpu_write_data;
            mask_q[wr_ptr_q] <= cpu_sign_mask;
        end
    end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Scoreboard bench for dmem_store_buffer: a program-order memory model predicts cache writes and load results,
// a behavioural cache with random latency answers the DUT, and a negedge monitor compares everything it sees.
module tb_dmem_store_buffer;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } WrReq;

    localparam byte EvW = 8'h57;
    localparam byte EvR = 8'h52;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_write_data;
    logic        cpu_memwrite;
    logic        cpu_memread;
    logic [3:0]  cpu_sign_mask;
    logic [31:0] cpu_read_data;
    logic        cpu_stall;
    logic [31:0] cache_addr;
    logic [31:0] cache_write_data;
    logic        cache_memwrite;
    logic        cache_memread;
    logic [3:0]  cache_sign_mask;
    logic [31:0] cache_read_data = '0;
    logic        cache_stall = 1'b0;

    int          checkCount = 0;
    int          passCount  = 0;
    bit          hung       = 1'b0;

    WrReq        expWr[$];
    logic [35:0] expRdReq[$];
    logic [31:0] expLoad[$];
    byte         evLog[$];

    logic [31:0] refMem   [256];
    logic [31:0] cacheMem [256];
    bit          cacheReady = 1'b0;
    int          busyCnt    = 0;

    dmem_store_buffer #(.DEPTH(4), .PTR_W(2)) dut (
        .clk              (clk),
        .reset            (reset),
        .cpu_addr         (cpu_addr),
        .cpu_write_data   (cpu_write_data),
        .cpu_memwrite     (cpu_memwrite),
        .cpu_memread      (cpu_memread),
        .cpu_sign_mask    (cpu_sign_mask),
        .cpu_read_data    (cpu_read_data),
        .cpu_stall        (cpu_stall),
        .cache_addr       (cache_addr),
        .cache_write_data (cache_write_data),
        .cache_memwrite   (cache_memwrite),
        .cache_memread    (cache_memread),
        .cache_sign_mask  (cache_sign_mask),
        .cache_read_data  (cache_read_data),
        .cache_stall      (cache_stall)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] initWord(input int i);
        return 32'(i) * 32'h9E3779B1 + 32'h0000_1234;
    endfunction

    // Byte/half/word store merge into a memory word; mask[2:0] gives the size.
    function automatic logic [31:0] mergeStore(input logic [31:0] old, input logic [31:0] addr,
                                               input logic [31:0] data, input logic [3:0] mask);
        logic [31:0] r;
        int          off;
        r   = old;
        off = int'(addr[1:0]) * 8;
        case (mask[2:0])
            3'b001:  r[off +: 8] = data[7:0];
            3'b011:  r[(addr[1] ? 16 : 0) +: 16] = data[15:0];
            default: r = data;
        endcase
        return r;
    endfunction

    // Load extraction; mask[3]=1 sign-extends sub-word results.
    function automatic logic [31:0] loadExtract(input logic [31:0] word, input logic [31:0] addr,
                                                input logic [3:0] mask);
        logic [7:0]  b;
        logic [15:0] h;
        int          off;
        off = int'(addr[1:0]) * 8;
        b   = word[off +: 8];
        h   = word[(addr[1] ? 16 : 0) +: 16];
        case (mask[2:0])
            3'b001:  return mask[3] ? {{24{b[7]}}, b} : {24'h0, b};
            3'b011:  return mask[3] ? {{16{h[15]}}, h} : {16'h0, h};
            default: return word;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [67:0] actual, input logic [67:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Behavioural cache: applies the strobed request, then holds clk_stall for 1..3 cycles.
    always @(posedge clk) begin
        if (!cacheReady) begin
            for (int i = 0; i < 256; i++) cacheMem[i] <= initWord(i);
            cacheReady <= 1'b1;
        end else if (cache_memwrite) begin
            cacheMem[cache_addr[9:2]] <= mergeStore(cacheMem[cache_addr[9:2]], cache_addr,
                                                    cache_write_data, cache_sign_mask);
            busyCnt     <= int'($urandom_range(1, 3));
            cache_stall <= 1'b1;
        end else if (cache_memread) begin
            cache_read_data <= loadExtract(cacheMem[cache_addr[9:2]], cache_addr, cache_sign_mask);
            busyCnt         <= int'($urandom_range(1, 3));
            cache_stall     <= 1'b1;
        end else if (busyCnt > 1) begin
            busyCnt <= busyCnt - 1;
        end else begin
            busyCnt     <= 0;
            cache_stall <= 1'b0;
        end
    end

    // Monitor: pops expectations whenever the DUT strobes the cache or completes a load.
    initial begin
        logic [67:0] heldBus;
        bit          holdChk;
        WrReq        w;
        holdChk = 1'b0;
        heldBus = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                holdChk = 1'b0;
            end else begin
                if (cache_memwrite && cache_memread) checkOutput("strobeOverlap", 68'(cache_memread), 68'(0));
                if (holdChk && !cache_memwrite && !cache_memread) begin
                    checkOutput("busHold", {cache_addr, cache_write_data, cache_sign_mask}, heldBus);
                    if (!cache_stall) holdChk = 1'b0;
                end
                if (cache_memwrite) begin
                    evLog.push_back(EvW);
                    if (expWr.size() == 0) begin
                        checkOutput("spuriousWrite", 68'(cache_memwrite), 68'(0));
                    end else begin
                        w = expWr.pop_front();
                        checkOutput("writeReq", {cache_addr, cache_write_data, cache_sign_mask}, 68'(w));
                    end
                    heldBus = {cache_addr, cache_write_data, cache_sign_mask};
                    holdChk = 1'b1;
                end
                if (cache_memread) begin
                    evLog.push_back(EvR);
                    if (expRdReq.size() == 0) begin
                        checkOutput("spuriousRead", 68'(cache_memread), 68'(0));
                    end else begin
                        checkOutput("readReq", 68'({cache_addr, cache_sign_mask}), 68'(expRdReq.pop_front()));
                    end
                    heldBus = {cache_addr, cache_write_data, cache_sign_mask};
                    holdChk = 1'b1;
                end
                if (cpu_memread && !cpu_stall) begin
                    if (expLoad.size() == 0) begin
                        checkOutput("spuriousLoadDone", 68'(cpu_memread), 68'(0));
                    end else begin
                        checkOutput("loadData", 68'(cpu_read_data), 68'(expLoad.pop_front()));
                    end
                end
            end
        end
    end

    // Presents one CPU memory op, holds it while stalled, and records the program-order effect.
    task automatic applyStimulus(input bit isStore, input logic [31:0] addr, input logic [31:0] data,
                                 input logic [3:0] mask, output bit sawStall);
        int guard;
        sawStall       = 1'b0;
        cpu_addr       = addr;
        cpu_write_data = data;
        cpu_sign_mask  = mask;
        cpu_memwrite   = isStore;
        cpu_memread    = !isStore;
        if (!isStore) begin
            expRdReq.push_back({addr, mask});
            expLoad.push_back(loadExtract(refMem[addr[9:2]], addr, mask));
        end
        guard = 0;
        @(negedge clk);
        while (cpu_stall && guard < 60) begin
            sawStall = 1'b1;
            guard++;
            @(negedge clk);
        end
        if (cpu_stall) begin
            checkOutput("stallTimeout", 68'(cpu_stall), 68'(0));
            hung = 1'b1;
        end else if (isStore) begin
            refMem[addr[9:2]] = mergeStore(refMem[addr[9:2]], addr, data, mask);
            expWr.push_back('{addr: addr, data: data, mask: mask});
        end
        @(posedge clk);
        #1;
        cpu_memwrite = 1'b0;
        cpu_memread  = 1'b0;
    endtask

    task automatic waitDrain();
        int guard;
        guard = 0;
        while (expWr.size() != 0 && guard < 200) begin
            @(posedge clk);
            guard++;
        end
        if (expWr.size() != 0) checkOutput("drainTimeout", 68'(expWr.size()), 68'(0));
        repeat (6) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: time limit reached after %0d checks", checkCount);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit          s;
        bit          stalls[5];
        logic [31:0] a;
        logic [3:0]  m;
        for (int i = 0; i < 256; i++) refMem[i] = initWord(i);
        reset = 1'b1;
        cpu_addr = '0; cpu_write_data = '0; cpu_sign_mask = '0;
        cpu_memwrite = 1'b0; cpu_memread = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rstMemwrite", 68'(cache_memwrite), 68'(0));
        checkOutput("rstMemread", 68'(cache_memread), 68'(0));
        checkOutput("rstCacheBus", {cache_addr, cache_write_data, cache_sign_mask}, 68'(0));
        checkOutput("rstReadData", 68'(cpu_read_data), 68'(0));
        checkOutput("rstStall", 68'(cpu_stall), 68'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Single store drains without stalling the core.
        evLog.delete();
        applyStimulus(1'b1, 32'h1000, 32'hDEADBEEF, 4'b0111, s);
        checkOutput("t1Stall", 68'(s), 68'(0));
        waitDrain();
        checkOutput("t1WriteCount", 68'(evLog.size()), 68'(1));

        // Five back-to-back stores: only the fifth meets a full buffer.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 32'h1010 + 32'(i * 4), $urandom(), 4'b0111, stalls[i]);
        end
        for (int i = 0; i < 5; i++) checkOutput($sformatf("t2Stall%0d", i), 68'(stalls[i]), 68'(i == 4));
        waitDrain();

        // Load hitting a queued store waits for the drain.
        evLog.delete();
        applyStimulus(1'b1, 32'h1004, 32'h11223344, 4'b0111, s);
        applyStimulus(1'b0, 32'h1004, 32'h0, 4'b0111, s);
        checkOutput("t3Data", 68'(cpu_read_data), 68'(32'h11223344));
        waitDrain();
        checkOutput("t3Order", {evLog[0], evLog[1]}, {EvW, EvR});

        // Non-hitting load overtakes the queued store.
        evLog.delete();
        applyStimulus(1'b1, 32'h1008, 32'hCAFEF00D, 4'b0111, s);
        applyStimulus(1'b0, 32'h100C, 32'h0, 4'b0111, s);
        waitDrain();
        checkOutput("t4Order", {evLog[0], evLog[1]}, {EvR, EvW});

        // Byte store then signed byte load of the same location.
        applyStimulus(1'b1, 32'h1005, 32'h00000080, 4'b0001, s);
        applyStimulus(1'b0, 32'h1005, 32'h0, 4'b1001, s);
        checkOutput("t5Data", 68'(cpu_read_data), 68'(32'hFFFFFF80));
        waitDrain();

        // Reset while the head entry is in its cache wait with three entries queued.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h1300 + 32'(i * 4), $urandom(), 4'b0111, s);
        reset = 1'b1;
        expWr.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("t6Strobes", {cache_memwrite, cache_memread}, 68'(0));
        checkOutput("t6CacheBus", {cache_addr, cache_write_data, cache_sign_mask}, 68'(0));
        checkOutput("t6ReadData", 68'(cpu_read_data), 68'(0));
        repeat (10) @(posedge clk);
        #1;
        applyStimulus(1'b1, 32'h1018, 32'h0BADC0DE, 4'b0111, s);
        applyStimulus(1'b0, 32'h1018, 32'h0, 4'b0111, s);
        checkOutput("t6Reuse", 68'(cpu_read_data), 68'(32'h0BADC0DE));
        waitDrain();

        // Random mix of sized stores and loads over a small address window.
        for (int n = 0; n < 250 && !hung; n++) begin
            int sz;
            sz = int'($urandom_range(0, 2));
            a  = 32'h1000 + 32'($urandom_range(0, 7) * 4);
            case (sz)
                0:       begin a = a + 32'($urandom_range(0, 3)); m = 4'b0001; end
                1:       begin a = a + 32'($urandom_range(0, 1) * 2); m = 4'b0011; end
                default: m = 4'b0111;
            endcase
            if ($urandom_range(0, 9) < 6) begin
                applyStimulus(1'b1, a, $urandom(), m, s);
            end else begin
                m[3] = 1'($urandom_range(0, 1));
                applyStimulus(1'b0, a, 32'h0, m, s);
            end
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1;
            end
        end
        waitDrain();
        checkOutput("pendingLoads", 68'(expLoad.size()), 68'(0));
        checkOutput("pendingReads", 68'(expRdReq.size()), 68'(0));

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
